// File: rtl/hex_life_sweep.sv
// Hex-grid toroidal life engine: sweeps the board one cell per clock through
// an external neighbour summer, then commits the next generation at once.
module hex_life_sweep #(
   parameter int          ROWS         = 8,
   parameter int          COLS         = 8,
   parameter int          NBITS        = 3,
   parameter logic [7:0]  BIRTH_MASK   = 8'h04,
   parameter logic [7:0]  SURVIVE_MASK = 8'h18,
   localparam int         NCELL        = ROWS * COLS,
   localparam int         AW           = $clog2(NCELL)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic               wr_data,
   input  logic [AW-1:0]      rd_addr,
   output logic               rd_data,
   output logic [6*NBITS-1:0] addends,
   input  logic [NBITS-1:0]   sum,
   output logic [15:0]        gen
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SWEEP  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]       r_state;
   logic [NCELL-1:0] r_cur;
   logic [NCELL-1:0] r_nxt;
   logic [AW-1:0]    r_idx;
   logic [RW-1:0]    r_row;
   logic [CW-1:0]    r_col;
   logic [15:0]      r_gen;
   logic             r_done;

   logic [RW-1:0]    w_rm;
   logic [RW-1:0]    w_rp;
   logic [CW-1:0]    w_cm;
   logic [CW-1:0]    w_cp;
   logic [5:0]       w_nb;
   logic             w_sweep;
   logic             w_self;
   logic             w_new;
   logic             w_last;

   function automatic logic [AW-1:0] f_cell(
      input logic [RW-1:0] r,
      input logic [CW-1:0] c
   );
      return AW'(r) * AW'(COLS) + AW'(c);
   endfunction

   // Toroidal wrap of the row/column neighbours
   assign w_rm = (r_row == '0) ? RW'(ROWS - 1) : r_row - 1'b1;
   assign w_rp = (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
   assign w_cm = (r_col == '0) ? CW'(COLS - 1) : r_col - 1'b1;
   assign w_cp = (r_col == CW'(COLS - 1)) ? '0 : r_col + 1'b1;

   assign w_nb[0] = r_cur[f_cell(r_row, w_cm)];
   assign w_nb[1] = r_cur[f_cell(r_row, w_cp)];
   assign w_nb[2] = r_cur[f_cell(w_rm, r_col)];
   assign w_nb[3] = r_cur[f_cell(w_rm, w_cp)];
   assign w_nb[4] = r_cur[f_cell(w_rp, w_cm)];
   assign w_nb[5] = r_cur[f_cell(w_rp, r_col)];

   assign w_sweep = (r_state == S_SWEEP);
   assign w_self  = r_cur[r_idx];
   assign w_new   = w_self ? SURVIVE_MASK[sum] : BIRTH_MASK[sum];
   assign w_last  = (r_idx == AW'(NCELL - 1));

   always_comb begin
      addends = '0;
      for (int k = 0; k < 6; k++) begin
         addends[k*NBITS +: NBITS] =
            {{(NBITS-1){1'b0}}, w_nb[k] & w_sweep};
      end
   end

   assign busy    = (r_state == S_SWEEP) || (r_state == S_COMMIT);
   assign done    = r_done;
   assign gen     = r_gen;
   assign rd_data = r_cur[rd_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cur   <= '0;
         r_nxt   <= '0;
         r_idx   <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_gen   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (wr_en) begin
                  r_cur[wr_addr] <= wr_data;
               end
               if (start) begin
                  r_state <= S_SWEEP;
                  r_idx   <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            S_SWEEP: begin
               r_nxt[r_idx] <= w_new;
               if (w_last) begin
                  r_state <= S_COMMIT;
               end else begin
                  r_idx <= r_idx + 1'b1;
                  if (r_col == CW'(COLS - 1)) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            S_COMMIT: begin
               r_cur   <= r_nxt;
               r_gen   <= r_gen + 16'd1;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
